// File: rtl/uart_pkg.sv
// Shared constants, state encoding and STATUS register layout for the UART receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  localparam logic [1:0] RXDATA_OFS = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;

  localparam int ST_NEMPTY_BIT = 0;
  localparam int ST_OVR_BIT    = 1;
  localparam int ST_FERR_BIT   = 2;
  localparam int ST_COUNT_LSB  = 4;

  function automatic logic [31:0] pack_status(input logic [4:0] count, input logic ferr,
                                              input logic ovr, input logic nempty);
    logic [31:0] s;
    s = '0;
    s[ST_COUNT_LSB +: 5] = count;
    s[ST_FERR_BIT]       = ferr;
    s[ST_OVR_BIT]        = ovr;
    s[ST_NEMPTY_BIT]     = nempty;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// Peripheral bus seen by the UART receiver: load/store strobes, data and the receive interrupt.
interface uart_rx_mmio_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  sel;
  logic [1:0]            addr;
  logic                  re;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rx_irq;

  modport master (output sel, addr, re, we, wdata, input rdata, rx_irq);
  modport slave  (input sel, addr, re, we, wdata, output rdata, rx_irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO only succeeds when a pop frees a slot that cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: 16x oversampling front end, byte FIFO and RXDATA/STATUS registers.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronised input
// START | timing to mid start bit to reject glitches
// DATA  | sampling 8 data bits LSB first, one per 16 ticks
// STOP  | sampling stop bit, then push byte or flag framing error
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       uart_rx_i,
  uart_rx_mmio_if.slave bus
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic          rx_meta_q, rx_s_q;
  rx_state_e     state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    tcnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          push_q, ferr_evt_q;
  logic          tick;

  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [7:0]    fifo_dout;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic          rd, wr, pop;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (state_q != IDLE) && (presc_q == PW'(DIV - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tcnt_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      ferr_evt_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_evt_q <= 1'b0;
      if (state_q == IDLE || tick) presc_q <= '0;
      else                         presc_q <= presc_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            tcnt_q  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tcnt_q == 4'(MID_TICK)) begin
              tcnt_q <= '0;
              idx_q  <= '0;
              state_q <= rx_s_q ? IDLE : DATA;
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tcnt_q <= tcnt_q + 4'd1;
            if (tcnt_q == 4'(OVERSAMPLE - 1)) begin
              shift_q[idx_q] <= rx_s_q;
              idx_q          <= idx_q + 3'd1;
              if (idx_q == 3'd7) state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            tcnt_q <= tcnt_q + 4'd1;
            if (tcnt_q == 4'(OVERSAMPLE - 1)) begin
              state_q    <= IDLE;
              push_q     <= rx_s_q;
              ferr_evt_q <= !rx_s_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_q),
    .pop_i   (pop),
    .din_i   (shift_q),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign rd  = bus.sel && bus.re;
  assign wr  = bus.sel && bus.we;
  assign pop = rd && (bus.addr == RXDATA_OFS);

  // Flag set events take priority over a same-cycle write-1-to-clear.
  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr && bus.addr == STATUS_OFS) begin
      if (bus.wdata[ST_OVR_BIT])  ovr_d  = 1'b0;
      if (bus.wdata[ST_FERR_BIT]) ferr_d = 1'b0;
    end
    if (push_q && fifo_full && !pop) ovr_d  = 1'b1;
    if (ferr_evt_q)                  ferr_d = 1'b1;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (bus.addr)
        RXDATA_OFS: rdata_d = fifo_empty ? '0 : DATA_WIDTH'(fifo_dout);
        STATUS_OFS: rdata_d = DATA_WIDTH'(pack_status(5'(fifo_count), ferr_q, ovr_q, !fifo_empty));
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rx_irq = !fifo_empty;

  logic unused_wdata;
  assign unused_wdata = ^{bus.wdata[DATA_WIDTH-1:3], bus.wdata[0]};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio at DIV=1 (16 clocks per bit): frame table plus corner sequences.
module tb_uart_rx_mmio;

  logic clk = 1'b0;
  logic reset;
  logic uart_rx;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx_mmio_if #(.DATA_WIDTH(32)) bus ();

  uart_rx_mmio #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (4),
    .DATA_WIDTH (32)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .uart_rx_i (uart_rx),
    .bus       (bus)
  );

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [31:0] exp_status;
    logic [31:0] exp_rxdata;
    logic [31:0] clr;
    logic [31:0] exp_status_after;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; start bit edge lands before the next posedge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stop;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.sel  = 1'b1;
    bus.re   = 1'b1;
    bus.addr = a;
    @(negedge clk);
    bus.sel = 1'b0;
    bus.re  = 1'b0;
    d = bus.rdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] w);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = w;
    @(negedge clk);
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  initial begin
    logic [31:0] d;

    vecs[0] = '{8'hA5, 1'b1, 32'h11, 32'hA5, 32'h0, 32'h0};
    vecs[1] = '{8'h00, 1'b1, 32'h11, 32'h00, 32'h0, 32'h0};
    vecs[2] = '{8'hFF, 1'b1, 32'h11, 32'hFF, 32'h0, 32'h0};
    vecs[3] = '{8'h3C, 1'b0, 32'h04, 32'h00, 32'h4, 32'h0};
    vecs[4] = '{8'h81, 1'b1, 32'h11, 32'h81, 32'h0, 32'h0};
    vecs[5] = '{8'h5A, 1'b0, 32'h04, 32'h00, 32'h2, 32'h4};
    vecs[6] = '{8'h96, 1'b1, 32'h15, 32'h96, 32'h4, 32'h0};

    reset     = 1'b1;
    uart_rx   = 1'b1;
    bus.sel   = 1'b0;
    bus.re    = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = '0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_irq", 32'(bus.rx_irq), 32'h0);
    bus_read(2'd1, d);
    check("reset_status", d, 32'h0);

    // Short low pulse must be rejected at the mid start-bit check.
    uart_rx = 1'b0;
    idle(6);
    uart_rx = 1'b1;
    idle(30);
    check("glitch_irq", 32'(bus.rx_irq), 32'h0);
    bus_read(2'd1, d);
    check("glitch_status", d, 32'h0);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      check($sformatf("v%0d_irq", i), 32'(bus.rx_irq), 32'(vecs[i].stop));
      idle(30);
      bus_read(2'd1, d);
      check($sformatf("v%0d_status", i), d, vecs[i].exp_status);
      bus_read(2'd0, d);
      check($sformatf("v%0d_rxdata", i), d, vecs[i].exp_rxdata);
      bus_write(2'd1, vecs[i].clr);
      bus_read(2'd1, d);
      check($sformatf("v%0d_status_after", i), d, vecs[i].exp_status_after);
    end

    // Framing error raised in the same cycle as a W1C store of ferr: set wins.
    fork
      send_frame(8'h3C, 1'b0);
      begin
        repeat (155) @(posedge clk);
        @(negedge clk);
        bus_write(2'd1, 32'h4);
      end
    join
    idle(30);
    bus_read(2'd1, d);
    check("ferr_set_wins", d, 32'h4);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, d);
    check("ferr_cleared", d, 32'h0);

    // Five frames into a 4-deep FIFO with no reads: overrun.
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    idle(30);
    bus_read(2'd1, d);
    check("ovr_status", d, 32'h43);
    bus_read(2'd2, d);
    check("reserved2_read", d, 32'h0);
    bus_read(2'd3, d);
    check("reserved3_read", d, 32'h0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'h6);
    bus_read(2'd1, d);
    check("ignored_stores", d, 32'h43);
    idle(5);
    check("rdata_hold", bus.rdata, 32'h43);
    for (int b = 1; b <= 4; b++) begin
      bus_read(2'd0, d);
      check($sformatf("ovr_read%0d", b), d, 32'(b));
    end
    bus_read(2'd0, d);
    check("ovr_read_empty", d, 32'h0);
    bus_read(2'd1, d);
    check("ovr_status_empty", d, 32'h2);
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, d);
    check("ovr_cleared", d, 32'h0);

    // Pop lands on the same edge the 5th byte is pushed into the full FIFO.
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (155) @(posedge clk);
        @(negedge clk);
        bus_read(2'd0, d);
      end
    join
    check("pushpop_first", d, 32'h01);
    idle(30);
    bus_read(2'd1, d);
    check("pushpop_status", d, 32'h41);
    for (int b = 2; b <= 5; b++) begin
      bus_read(2'd0, d);
      check($sformatf("pushpop_read%0d", b), d, 32'(b));
    end
    bus_read(2'd1, d);
    check("pushpop_status_empty", d, 32'h0);

    // Reset in the middle of data bit 3 with a byte already buffered.
    send_frame(8'h5A, 1'b1);
    idle(30);
    bus_read(2'd1, d);
    check("prereset_status", d, 32'h11);
    uart_rx = 1'b0;
    idle(16);
    for (int i = 0; i < 3; i++) begin
      uart_rx = i[0];
      idle(16);
    end
    uart_rx = 1'b1;
    idle(6);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("midreset_rdata", bus.rdata, 32'h0);
    check("midreset_irq", 32'(bus.rx_irq), 32'h0);
    idle(20);
    bus_read(2'd1, d);
    check("midreset_status", d, 32'h0);
    send_frame(8'h7E, 1'b1);
    check("postreset_irq", 32'(bus.rx_irq), 32'h1);
    idle(30);
    bus_read(2'd0, d);
    check("postreset_rxdata", d, 32'h7E);
    bus_read(2'd1, d);
    check("postreset_status", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
